// File: rtl/stream_mux_rr.sv
// ============================================================================
// Module      : stream_mux_rr
// Description : N-to-1 registered valid/ready stream mux with round-robin
//               arbitration; y_sel tags each word with its source channel.
//               Define STREAM_MUX_PRIO_EN for strict fixed priority instead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux_rr #(
    parameter int N_CH  = 2,
    parameter int WIDTH = 8,
    localparam int SW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       i_valid,
    input  logic [N_CH*WIDTH-1:0] i_data,
    output logic [N_CH-1:0]       i_ready,
    output logic                  y_valid,
    output logic [WIDTH-1:0]      y_data,
    output logic [SW-1:0]         y_sel,
    input  logic                  y_ready
);

    logic              r_y_valid;
    logic [WIDTH-1:0]  r_y_data;
    logic [SW-1:0]     r_y_sel;

    logic              w_load;
    logic              w_found;
    logic              w_xfer;
    logic [SW-1:0]     w_grant;
    logic [WIDTH-1:0]  w_gdata;

`ifdef STREAM_MUX_PRIO_EN
    // Descending scan so the lowest-index requester is the last writer.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (i_valid[k]) begin
                w_found = 1'b1;
                w_grant = SW'(k);
            end
        end
    end
`else
    logic [SW-1:0] r_last;

    // Cyclic search from last+1: channels above last first, then wrap to 0..last.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!w_found && i_valid[k] && (SW'(k) > r_last)) begin
                w_found = 1'b1;
                w_grant = SW'(k);
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (!w_found && i_valid[k] && (SW'(k) <= r_last)) begin
                w_found = 1'b1;
                w_grant = SW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= SW'(N_CH - 1);
        end else if (w_xfer) begin
            r_last <= w_grant;
        end
    end
`endif

    assign w_load = !r_y_valid || y_ready;
    assign w_xfer = w_load && w_found && !rst;

    always_comb begin
        w_gdata = '0;
        i_ready = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_grant == SW'(k)) begin
                w_gdata    = i_data[k*WIDTH +: WIDTH];
                i_ready[k] = w_xfer;
            end
        end
    end

    // One-entry output register; a same-cycle load overwrites a completing word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
            r_y_sel   <= '0;
        end else if (w_xfer) begin
            r_y_valid <= 1'b1;
            r_y_data  <= w_gdata;
            r_y_sel   <= w_grant;
        end else if (y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    assign y_valid = r_y_valid;
    assign y_data  = r_y_data;
    assign y_sel   = r_y_sel;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
// ============================================================================
// Module      : tb_stream_mux_rr
// Description : Directed self-checking bench for stream_mux_rr (2- and 4-channel
//               instances); expectations follow STREAM_MUX_PRIO_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [1:0]  v2 = '0;
    logic [15:0] d2 = '0;
    logic [1:0]  r2;
    logic        yv2;
    logic [7:0]  yd2;
    logic        ys2;
    logic        yr2 = 1'b1;

    logic [3:0]  v4 = '0;
    logic [31:0] d4 = '0;
    logic [3:0]  r4;
    logic        yv4;
    logic [7:0]  yd4;
    logic [1:0]  ys4;
    logic        yr4 = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.N_CH(2), .WIDTH(8)) dut2 (
        .clk(clk), .rst(rst), .i_valid(v2), .i_data(d2), .i_ready(r2),
        .y_valid(yv2), .y_data(yd2), .y_sel(ys2), .y_ready(yr2)
    );

    stream_mux_rr #(.N_CH(4), .WIDTH(8)) dut4 (
        .clk(clk), .rst(rst), .i_valid(v4), .i_data(d4), .i_ready(r4),
        .y_valid(yv4), .y_data(yd4), .y_sel(ys4), .y_ready(yr4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: ready must stay low while rst is high even with requests.
        tick();
        v2 = 2'b11;
        #1 chk("rst_ready2", 32'(r2), 32'h0);
        tick();
        chk("rst_yv2", 32'(yv2), 32'h0);
        chk("rst_yd2", 32'(yd2), 32'h0);
        chk("rst_ys2", 32'(ys2), 32'h0);
        chk("rst_yv4", 32'(yv4), 32'h0);
        rst = 1'b0;
        v2  = 2'b00;

        // Single word on ch1.
        v2 = 2'b10;
        d2 = {8'hA5, 8'h3C};
        #1 chk("single_ready", 32'(r2), 32'h2);
        tick();
        v2 = 2'b00;
        chk("single_yv", 32'(yv2), 32'h1);
        chk("single_yd", 32'(yd2), 32'hA5);
        chk("single_ys", 32'(ys2), 32'h1);
        tick();
        chk("single_drop", 32'(yv2), 32'h0);
        chk("single_hold", 32'(yd2), 32'hA5);

`ifndef STREAM_MUX_PRIO_EN
        // Round-robin across 4 continuously-valid channels.
        v4 = 4'hF;
        d4 = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 8; i++) begin
            #1 chk("rr_ready", 32'(r4), 32'(1 << (i % 4)));
            tick();
            chk("rr_yv", 32'(yv4), 32'h1);
            chk("rr_ys", 32'(ys4), 32'(i % 4));
            chk("rr_yd", 32'(yd4), 32'(8'h11 * ((i % 4) + 1)));
        end

        // Backpressure with word from ch3 held.
        yr4 = 1'b0;
        #1 chk("bp_ready0", 32'(r4), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_ready", 32'(r4), 32'h0);
            chk("bp_yv", 32'(yv4), 32'h1);
            chk("bp_ys", 32'(ys4), 32'h3);
            chk("bp_yd", 32'(yd4), 32'h44);
        end
        yr4 = 1'b1;
        #1 chk("bp_release_ready", 32'(r4), 32'h1);
        tick();
        chk("bp_release_yv", 32'(yv4), 32'h1);
        chk("bp_release_ys", 32'(ys4), 32'h0);
        chk("bp_release_yd", 32'(yd4), 32'h11);

        // Sparse requests with wrap: set last=2, then only ch1, then ch1+ch2.
        v4 = 4'b0100;
        #1 chk("sp_ready_ch2", 32'(r4), 32'h4);
        tick();
        chk("sp_ys_ch2", 32'(ys4), 32'h2);
        v4 = 4'b0010;
        #1 chk("sp_ready_wrap", 32'(r4), 32'h2);
        tick();
        chk("sp_ys_wrap", 32'(ys4), 32'h1);
        chk("sp_yd_wrap", 32'(yd4), 32'h22);
        v4 = 4'b0110;
        #1 chk("sp_ready_next", 32'(r4), 32'h4);
        tick();
        chk("sp_ys_next", 32'(ys4), 32'h2);
        chk("sp_yd_next", 32'(yd4), 32'h33);
        v4 = 4'b0000;
        tick();
        chk("sp_idle_yv", 32'(yv4), 32'h0);
`else
        // Fixed priority: ch0 always wins, then ch1 once ch0 drops.
        v4 = 4'hF;
        d4 = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 4; i++) begin
            #1 chk("pr_ready0", 32'(r4), 32'h1);
            tick();
            chk("pr_yv0", 32'(yv4), 32'h1);
            chk("pr_ys0", 32'(ys4), 32'h0);
            chk("pr_yd0", 32'(yd4), 32'h11);
        end
        v4 = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            #1 chk("pr_ready1", 32'(r4), 32'h2);
            tick();
            chk("pr_ys1", 32'(ys4), 32'h1);
            chk("pr_yd1", 32'(yd4), 32'h22);
        end
        v4 = 4'b0000;
        tick();
        chk("pr_idle_yv", 32'(yv4), 32'h0);
`endif

        // Reset while a word is held under backpressure (last=0 before reset).
        yr2 = 1'b0;
        v2  = 2'b01;
        #1 chk("mr_ready_load", 32'(r2), 32'h1);
        tick();
        v2 = 2'b11;
        chk("mr_held_yv", 32'(yv2), 32'h1);
        chk("mr_held_ys", 32'(ys2), 32'h0);
        chk("mr_held_yd", 32'(yd2), 32'h3C);
        chk("mr_stall_ready", 32'(r2), 32'h0);
        rst = 1'b1;
        #1 chk("mr_rst_ready", 32'(r2), 32'h0);
        tick();
        rst = 1'b0;
        chk("mr_yv", 32'(yv2), 32'h0);
        chk("mr_yd", 32'(yd2), 32'h0);
        chk("mr_ys", 32'(ys2), 32'h0);
        #1 chk("mr_first_grant", 32'(r2), 32'h1);
        yr2 = 1'b1;
        tick();
        chk("mr_out0_ys", 32'(ys2), 32'h0);
        chk("mr_out0_yd", 32'(yd2), 32'h3C);
`ifndef STREAM_MUX_PRIO_EN
        #1 chk("mr_second_grant", 32'(r2), 32'h2);
        tick();
        chk("mr_out1_ys", 32'(ys2), 32'h1);
        chk("mr_out1_yd", 32'(yd2), 32'hA5);
`else
        #1 chk("mr_second_grant", 32'(r2), 32'h1);
        tick();
        chk("mr_out1_ys", 32'(ys2), 32'h0);
        chk("mr_out1_yd", 32'(yd2), 32'h3C);
`endif
        v2 = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- N-to-1 registered stream multiplexer with round-robin arbitration. It is the combining end for the team's demux blocks.
- Merges N valid/ready input channels onto one output stream and tags each word with its source index on y_sel. A downstream demux can use y_sel directly as its select.
- Sits between per-channel producers and a shared link or bus.

Parameters:
- N_CH, 2, number of input channels (2..16).
- WIDTH, 8, data word width in bits.
- SW, $clog2(N_CH) (minimum 1), width of y_sel. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- i_valid  input  N_CH  per-channel word-valid
- i_data  input  N_CH*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
- i_ready  output  N_CH  per-channel accept (combinational)
- y_valid  output  1  output word valid (registered)
- y_data  output  WIDTH  output data (registered)
- y_sel  output  SW  source channel index of y_data (registered)
- y_ready  input  1  downstream accept

Behaviour:
- Reset (rst=1 at a clk edge):
  - y_valid=0, y_data=0, y_sel=0.
  - Round-robin pointer last=N_CH-1, so channel 0 has top priority after reset.
  - i_ready=0 during any cycle in which rst=1.
  - Reset mid-transfer discards the held output word and does not complete any pending input handshake.
- Output register is one entry. States: EMPTY (y_valid=0) and FULL (y_valid=1).
- Load condition: load = !y_valid | y_ready.
- Grant:
  - When load=1, the grant goes to the first channel with i_valid=1, searching cyclically from last+1 through last (wrap at N_CH-1 to 0).
  - i_ready[g]=1 for the granted channel only. All other i_ready bits are 0.
  - At most one i_ready bit is high per cycle.
  - i_ready never depends on i_data. It may depend on i_valid, y_valid, y_ready and last.
- Transfer: an input transfer occurs when i_valid[g] & i_ready[g].
  - On the clock edge: y_data<=i_data[g], y_sel<=g, y_valid<=1, last<=g.
- Output handshake: y_valid & y_ready completes the output.
  - If no input transfer occurs in the same cycle: y_valid<=0. y_data and y_sel hold their values.
  - Simultaneous output completion and input transfer: the new word replaces the old one and y_valid stays 1. This gives full throughput of one word per cycle.
- Stall: while y_valid=1 and y_ready=0, all i_ready=0 and y_data, y_sel, y_valid are stable.
- Latency: 1 cycle from input transfer to y_valid.
- Fairness: with all channels continuously valid and y_ready=1, grants cycle 0,1,...,N_CH-1,0,...
- last is updated only on a transfer. An idle channel does not consume a turn.
- No input valid: no grant, last unchanged, y_valid falls after the pending output is consumed.
- Input rule: sources must not drop i_valid or change i_data before the handshake. The block does not check this.

Optional Feature:
- Macro: STREAM_MUX_PRIO_EN.
- Defined:
  - Strict fixed priority: the lowest-index channel with i_valid=1 wins.
  - last is not used. It may be removed or tied off.
  - All other behaviour is unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Reset then single word: after reset with N_CH=2 and y_ready=1, drive i_valid=2'b10 with ch1 data 8'hA5.
  - Required: i_ready=2'b10 in the same cycle.
  - Next cycle: y_valid=1, y_data=A5, y_sel=1. Following cycle: y_valid=0.
- Round-robin: N_CH=4, all i_valid=1, y_ready=1 for 8 cycles.
  - Required: y_sel sequence 0,1,2,3,0,1,2,3 on consecutive cycles, y_valid continuously 1.
- Backpressure: hold y_ready=0 for 3 cycles while y_valid=1.
  - Required: i_ready=0 and y_data/y_sel unchanged for all 3 cycles.
  - Release y_ray_ready=1: the next grant goes to last+1 and the new word appears the next cycle with no bubble.
- Sparse plus wrap: N_CH=4, last=2, only ch1 valid.
  - Required: grant ch1 (search order 3,0,1), y_sel=1.
  - Then ch1 and ch2 valid: ch2 is granted first.
- Reset mid-operation: assert rst while y_valid=1 and y_ready=0.
  - Required: next cycle y_valid=0, y_data=0, y_sel=0. With ch0 and ch1 both valid, ch0 is granted first.
- Macro STREAM_MUX_PRIO_EN: N_CH=4, all i_valid=1, y_ready=1.
  - Required: y_sel=0 every cycle.
  - Drop ch0 valid: y_sel=1 every cycle.
